// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its pipeline neighbours.
//   NUM_REGS   : architectural register count
//   REG_ADDR_W : register index width
//   DATA_W     : register / data width
//   CNT_W      : width of each pending-write counter
//   PEND_MAX   : counter ceiling; issue is refused once a register reaches it
package regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [CNT_W-1:0]      pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = '1;

  // One registered write-back slot.
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    data_t     data;
  } wb_result_t;

  // An operand must wait while writes younger than the one on the write
  // port are outstanding. A write on the port this cycle covers one of them.
  function automatic logic must_stall(pend_cnt_t cnt, logic hit);
    return cnt > pend_cnt_t'(hit);
  endfunction

endpackage

// File: rtl/regfile_writeback_ctrl_if.sv
// Signal bundle between decode / MEM-WB / register file and the
// write-back controller.
//   issue_*      : decode announces an instruction that will write issue_rd
//   result_*     : MEM/WB result, always accepted
//   rs1/rs2      : decode read addresses
//   stall_*/fwd_*: per-read-port hazard indications, fwd_data value
//   RegWrite, write_register, write_data : register file write port
//   err_underflow: sticky retire-without-issue flag
// Modport slave is the controller, master is its environment.
interface regfile_writeback_ctrl_if;
  import regfile_pkg::*;

  logic      issue_valid;
  reg_addr_t issue_rd;
  logic      issue_ready;
  logic      result_valid;
  reg_addr_t result_rd;
  data_t     result_data;
  reg_addr_t rs1;
  reg_addr_t rs2;
  logic      stall_rs1;
  logic      stall_rs2;
  logic      fwd_rs1;
  logic      fwd_rs2;
  data_t     fwd_data;
  logic      RegWrite;
  reg_addr_t write_register;
  data_t     write_data;
  logic      err_underflow;

  modport slave (
    input  issue_valid, issue_rd, result_valid, result_rd, result_data, rs1, rs2,
    output issue_ready, stall_rs1, stall_rs2, fwd_rs1, fwd_rs2, fwd_data,
           RegWrite, write_register, write_data, err_underflow
  );

  modport master (
    output issue_valid, issue_rd, result_valid, result_rd, result_data, rs1, rs2,
    input  issue_ready, stall_rs1, stall_rs2, fwd_rs1, fwd_rs2, fwd_data,
           RegWrite, write_register, write_data, err_underflow
  );

endinterface

// File: rtl/pending_counter.sv
// Outstanding-write counter for one register.
//   clk, reset : clock, synchronous active-high reset
//   inc        : an instruction writing this register was issued
//   dec        : a write to this register is on the write port this cycle
//   count      : number of outstanding writes
//   underflow  : sticky, set when a write retires while count is zero
module pending_counter
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t count,
  output logic      underflow
);

  pend_cnt_t count_reg, count_next;
  logic      underflow_reg, underflow_next;

  always_comb begin
    count_next     = count_reg;
    underflow_next = underflow_reg;
    if (dec && count_reg == '0) underflow_next = 1'b1;
    // inc and dec together cancel; each direction saturates on its own.
    unique case ({inc, dec})
      2'b10: if (count_reg != PEND_MAX) count_next = count_reg + 1'b1;
      2'b01: if (count_reg != '0)       count_next = count_reg - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
    end
  end

  assign count     = count_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Writer-side controller of the register file. Registers each MEM/WB
// result for one cycle and drives the write port with it, tracks pending
// writes per register from decode issue, and produces stall/forward
// indications for both decode read ports.
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_writeback_ctrl_if.slave (issue, result, read
//                addresses, hazard outputs, write port, error flag)
module regfile_writeback_ctrl
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  regfile_writeback_ctrl_if.slave bus
);

  wb_result_t          wb_reg;
  logic                reg_write;
  logic                issue_ready_int;
  logic                issue_fire;
  logic                hit_rs1, hit_rs2;
  pend_cnt_t           pend [NUM_REGS];
  logic [NUM_REGS-1:0] uflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_reg <= '0;
    end else begin
      wb_reg <= '{valid: bus.result_valid, rd: bus.result_rd, data: bus.result_data};
    end
  end

  // A result held in the stage while reset is asserted is discarded rather
  // than written, so the write enable is masked in that cycle as well.
  assign reg_write = wb_reg.valid & ~reset;

  assign issue_ready_int = (pend[bus.issue_rd] != PEND_MAX);
  assign issue_fire      = bus.issue_valid & issue_ready_int;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
    pending_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (issue_fire && (bus.issue_rd == REG_ADDR_W'(gi))),
      .dec       (reg_write && (wb_reg.rd == REG_ADDR_W'(gi))),
      .count     (pend[gi]),
      .underflow (uflow[gi])
    );
  end

  assign hit_rs1 = reg_write && (wb_reg.rd == bus.rs1);
  assign hit_rs2 = reg_write && (wb_reg.rd == bus.rs2);

  assign bus.issue_ready    = issue_ready_int;
  assign bus.fwd_rs1        = hit_rs1;
  assign bus.fwd_rs2        = hit_rs2;
  assign bus.stall_rs1      = must_stall(pend[bus.rs1], hit_rs1);
  assign bus.stall_rs2      = must_stall(pend[bus.rs2], hit_rs2);
  assign bus.fwd_data       = wb_reg.data;
  assign bus.RegWrite       = reg_write;
  assign bus.write_register = wb_reg.rd;
  assign bus.write_data     = wb_reg.data;
  assign bus.err_underflow  = |uflow;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl: the stimulus process pushes
// expected write-backs into a queue; a monitor on the falling edge pops and
// compares them and checks hazard outputs against a pending-count model.
module tb_regfile_writeback_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  regfile_writeback_ctrl_if bus ();

  regfile_writeback_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  rd;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pend_m [16];
  bit   err_m = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial for (int i = 0; i < 16; i++) pend_m[i] = 0;

  // Monitor + reference model. Model state describes the DUT between edges;
  // it is advanced here to what the next rising edge should produce.
  always @(negedge clk) begin : monitor
    bit   exp_rw, hit1, hit2, ready_m, inc, dec;
    exp_t e;
    int   ird, wrd;
    exp_rw = 1'b0;
    e = '{0, 4'd0, 16'd0};
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_rw = !reset;
    end
    check("RegWrite", {31'd0, bus.RegWrite}, {31'd0, exp_rw});
    if (exp_rw) begin
      $display("wb cyc=%0d rd=%0d data=%h", cyc, bus.write_register, bus.write_data);
      check("write_register", {28'd0, bus.write_register}, {28'd0, e.rd});
      check("write_data", {16'd0, bus.write_data}, {16'd0, e.data});
      check("fwd_data", {16'd0, bus.fwd_data}, {16'd0, e.data});
    end
    ird     = int'(bus.issue_rd);
    ready_m = (pend_m[ird] != 3);
    hit1    = exp_rw && (e.rd == bus.rs1);
    hit2    = exp_rw && (e.rd == bus.rs2);
    check("issue_ready", {31'd0, bus.issue_ready}, {31'd0, ready_m});
    check("fwd_rs1", {31'd0, bus.fwd_rs1}, {31'd0, hit1});
    check("fwd_rs2", {31'd0, bus.fwd_rs2}, {31'd0, hit2});
    check("stall_rs1", {31'd0, bus.stall_rs1},
          {31'd0, pend_m[int'(bus.rs1)] > (hit1 ? 1 : 0)});
    check("stall_rs2", {31'd0, bus.stall_rs2},
          {31'd0, pend_m[int'(bus.rs2)] > (hit2 ? 1 : 0)});
    check("err_underflow", {31'd0, bus.err_underflow}, {31'd0, err_m});

    if (reset) begin
      for (int i = 0; i < 16; i++) pend_m[i] = 0;
      err_m = 1'b0;
      exp_q.delete();
    end else begin
      inc = bus.issue_valid && ready_m;
      dec = exp_rw;
      wrd = int'(e.rd);
      if (dec && pend_m[wrd] == 0) err_m = 1'b1;
      if (inc) pend_m[ird] = pend_m[ird] + 1;
      if (dec && pend_m[wrd] > 0) pend_m[wrd] = pend_m[wrd] - 1;
    end
  end

  task automatic step(bit iv, int ird, bit rv, int rrd, int rdat, int r1, int r2, bit rst);
    exp_t e;
    reset            = rst;
    bus.issue_valid  = iv;
    bus.issue_rd     = ird[3:0];
    bus.result_valid = rv;
    bus.result_rd    = rrd[3:0];
    bus.result_data  = rdat[15:0];
    bus.rs1          = r1[3:0];
    bus.rs2          = r2[3:0];
    if (rv && !rst) begin
      e = '{cyc + 1, rrd[3:0], rdat[15:0]};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
    bus.result_valid = 1'b0;
    bus.result_rd = '0;
    bus.result_data = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 1: result with nothing issued -> write then underflow
    step(0, 0, 1, 5, 'h1234, 5, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 2: issue r3, result two cycles later, forward in write cycle
    step(1, 3, 0, 0, 0, 3, 0, 0);
    step(0, 3, 0, 0, 0, 3, 0, 0);
    step(0, 3, 1, 3, 'hBEEF, 3, 0, 0);
    step(0, 3, 0, 0, 0, 3, 0, 0);
    step(0, 3, 0, 0, 0, 3, 0, 0);
    // 3: saturate r7, blocked fourth issue, one retirement reopens
    for (int i = 0; i < 4; i++) step(1, 7, 0, 0, 0, 7, 7, 0);
    step(0, 7, 1, 7, 'h0777, 7, 7, 0);
    step(0, 7, 0, 0, 0, 7, 7, 0);
    step(0, 7, 0, 0, 0, 7, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 4: two writes to r2 outstanding, forward yet still stall
    step(1, 2, 0, 0, 0, 0, 2, 0);
    step(1, 2, 0, 0, 0, 0, 2, 0);
    step(0, 2, 1, 2, 'h2222, 0, 2, 0);
    step(0, 2, 0, 0, 0, 0, 2, 0);
    step(0, 2, 0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 5: issue and retire r4 in the same cycle
    step(1, 4, 0, 0, 0, 4, 4, 0);
    step(0, 4, 1, 4, 'h4444, 4, 4, 0);
    step(1, 4, 0, 0, 0, 4, 4, 0);
    step(0, 4, 0, 0, 0, 4, 4, 0);
    // 6: registered result dropped by reset
    step(0, 9, 1, 9, 'h9999, 9, 9, 0);
    step(0, 9, 0, 0, 0, 9, 9, 1);
    step(0, 9, 0, 0, 0, 9, 9, 0);
    step(0, 9, 0, 0, 0, 9, 9, 0);
    // random traffic concentrated on a few registers
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(3, 0),
           $urandom_range(2, 0) == 0, $urandom_range(3, 0), $urandom_range(65535, 0),
           $urandom_range(4, 0), $urandom_range(4, 0),
           $urandom_range(99, 0) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
